// File: rtl/bp_pkg.sv
// Shared types for the branch predictor controller:
// 2-bit counters, in-flight entry layout, counter update.
package bp_pkg;

  localparam int BP_IDX_W = 4;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'd0;
  localparam ctr2_t CTR_WNT = 2'd1;
  localparam ctr2_t CTR_WT  = 2'd2;
  localparam ctr2_t CTR_ST  = 2'd3;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } bp_entry_t;

  function automatic ctr2_t sat_update(
    input ctr2_t ctr,
    input logic  taken
  );
    ctr2_t r;
    r = ctr;
    unique case (1'b1)
      taken  && (ctr != CTR_ST):  r = ctr + 2'd1;
      !taken && (ctr != CTR_SNT): r = ctr - 2'd1;
      default:                    r = ctr;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute <-> predictor bundle.
// master: fetch+execute side; slave: branch_pred_ctrl.
interface branch_pred_ctrl_if #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 3
);

  logic             fetch_valid;
  logic [PC_W-1:0]  fetch_pc;
  logic             pred_taken;
  logic             fetch_stall;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             mispredict;
  logic [CNT_W-1:0] inflight;

  modport master (
    output fetch_valid, fetch_pc,
    output resolve_valid, resolve_taken,
    input  pred_taken, fetch_stall,
    input  mispredict, inflight
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  resolve_valid, resolve_taken,
    output pred_taken, fetch_stall,
    output mispredict, inflight
  );

endinterface

// File: rtl/bp_inflight_fifo.sv
// In-order queue of outstanding predictions.
// push/pop/clear in; rdata (head), full, empty, count out.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  bp_entry_t     wdata_i,
  output bp_entry_t     rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  bp_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: it is only read while count != 0.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor controller: PHT of 2-bit counters,
// in-flight queue, training and mispredict pulse. clk, reset (async low), bp.
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter  int PC_W  = 64,
  parameter  int IDX_W = BP_IDX_W,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int NENT  = 1 << IDX_W
) (
  input  logic clk,
  input  logic reset,
  branch_pred_ctrl_if.slave bp
);

  ctr2_t            pht_q [NENT];
  ctr2_t            pht_d [NENT];
  logic             misp_q, misp_d;
  logic [IDX_W-1:0] fidx;
  logic             pred;
  bp_entry_t        head, wentry;
  logic             full, empty;
  logic             push, pop, flush_now;
  logic [CW-1:0]    count;
  logic             unused_pc;

  assign fidx      = bp.fetch_pc[IDX_W+1:2];
  assign unused_pc = ^{bp.fetch_pc[PC_W-1:IDX_W+2], bp.fetch_pc[1:0]};
  assign pred      = pht_q[fidx][1];

  assign pop       = bp.resolve_valid & ~empty;
  assign flush_now = pop & (head.pred != bp.resolve_taken);
  // Fetch in the flushing cycle is wrong-path and is dropped.
  assign push      = bp.fetch_valid & ~full & ~flush_now;

  assign wentry = '{idx: fidx, pred: pred};

  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush_now),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    pht_d  = pht_q;
    misp_d = flush_now;
    if (pop) begin
      pht_d[head.idx] = sat_update(pht_q[head.idx], bp.resolve_taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NENT; i++) pht_q[i] <= CTR_WNT;
      misp_q <= 1'b0;
    end else begin
      pht_q  <= pht_d;
      misp_q <= misp_d;
    end
  end

  assign bp.pred_taken  = pred;
  assign bp.fetch_stall = full;
  assign bp.mispredict  = misp_q;
  assign bp.inflight    = count;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl.
// Reference PHT + scoreboard queue of expected in-flight entries.
module tb_branch_pred_ctrl;
  import bp_pkg::*;

  localparam int PC_W  = 64;
  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int NENT  = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  branch_pred_ctrl_if #(.PC_W(PC_W), .CNT_W(CW)) bp ();

  branch_pred_ctrl #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  int checks   = 0;
  int failures = 0;

  ctr2_t     mdl_pht [NENT];
  bp_entry_t sb [$];

  logic obs_pred, obs_stall;
  logic exp_pred, exp_stall, exp_misp;

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) mdl_pht[i] = 2'd1;
    sb.delete();
  endtask

  task automatic drive_idle();
    bp.fetch_valid   = 1'b0;
    bp.fetch_pc      = '0;
    bp.resolve_valid = 1'b0;
    bp.resolve_taken = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive at negedge, sample combinational outputs,
  // advance the model, then step past the rising edge.
  task automatic step(
    input logic            fv,
    input logic [PC_W-1:0] pc,
    input logic            rv,
    input logic            rt
  );
    bp_entry_t        e;
    logic             flush;
    logic [IDX_W-1:0] i;
    @(negedge clk);
    bp.fetch_valid   = fv;
    bp.fetch_pc      = pc;
    bp.resolve_valid = rv;
    bp.resolve_taken = rt;
    #1;
    obs_pred  = bp.pred_taken;
    obs_stall = bp.fetch_stall;
    i         = pc[IDX_W+1:2];
    exp_pred  = mdl_pht[i][1];
    exp_stall = (sb.size() == DEPTH);
    flush     = 1'b0;
    if (rv && sb.size() != 0) begin
      e     = sb.pop_front();
      flush = (e.pred != rt);
      if (rt) begin
        if (mdl_pht[e.idx] != 2'd3) mdl_pht[e.idx] = mdl_pht[e.idx] + 2'd1;
      end else begin
        if (mdl_pht[e.idx] != 2'd0) mdl_pht[e.idx] = mdl_pht[e.idx] - 2'd1;
      end
    end
    if (flush) sb.delete();
    if (fv && !exp_stall && !flush) sb.push_back('{idx: i, pred: exp_pred});
    exp_misp = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bp.inflight !== 3'd0) begin
      failures++;
      $display("FAIL reset_inflight got=%0d exp=0", bp.inflight);
    end
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL reset_misp got=%0b exp=0", bp.mispredict);
    end
    checks++;
    if (bp.fetch_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%0b exp=0", bp.fetch_stall);
    end
    for (int i = 0; i < NENT; i++) begin
      checks++;
      if (dut.pht_q[i] !== 2'd1) begin
        failures++;
        $display("FAIL reset_pht[%0d] got=%0d exp=1", i, dut.pht_q[i]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    step(1'b1, 64'h40, 1'b0, 1'b0);
    checks++;
    if (obs_pred !== 1'b0) begin
      failures++;
      $display("FAIL basic_pred0 got=%0b exp=0", obs_pred);
    end
    checks++;
    if (bp.inflight !== 3'd1) begin
      failures++;
      $display("FAIL basic_inflight got=%0d exp=1", bp.inflight);
    end
    step(1'b0, 64'h0, 1'b1, 1'b1);
    checks++;
    if (bp.mispredict !== 1'b1) begin
      failures++;
      $display("FAIL basic_misp got=%0b exp=1", bp.mispredict);
    end
    checks++;
    if (dut.pht_q[0] !== 2'd2) begin
      failures++;
      $display("FAIL basic_pht0 got=%0d exp=2", dut.pht_q[0]);
    end
    step(1'b1, 64'h40, 1'b0, 1'b0);
    checks++;
    if (obs_pred !== 1'b1) begin
      failures++;
      $display("FAIL basic_pred1 got=%0b exp=1", obs_pred);
    end
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse_len got=%0b exp=0", bp.mispredict);
    end
    step(1'b0, 64'h0, 1'b1, 1'b1);
    checks++;
    if (bp.mispredict !== exp_misp) begin
      failures++;
      $display("FAIL basic_correct got=%0b exp=%0b", bp.mispredict, exp_misp);
    end
    checks++;
    if (dut.pht_q[0] !== 2'd3) begin
      failures++;
      $display("FAIL basic_pht0_sat got=%0d exp=3", dut.pht_q[0]);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 64'(k * 4), 1'b0, 1'b0);
    step(1'b1, 64'h10, 1'b0, 1'b0);
    checks++;
    if (obs_stall !== 1'b1) begin
      failures++;
      $display("FAIL full_stall got=%0b exp=1", obs_stall);
    end
    checks++;
    if (bp.inflight !== 3'd4) begin
      failures++;
      $display("FAIL full_inflight got=%0d exp=4", bp.inflight);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 64'h0, 1'b1, 1'b0);
      checks++;
      if (bp.mispredict !== 1'b0) begin
        failures++;
        $display("FAIL full_drain_misp[%0d] got=%0b exp=0", k, bp.mispredict);
      end
    end
    checks++;
    if (bp.inflight !== 3'd0) begin
      failures++;
      $display("FAIL full_drain_inflight got=%0d exp=0", bp.inflight);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut.pht_q[k] !== 2'd0) begin
        failures++;
        $display("FAIL full_pht[%0d] got=%0d exp=0", k, dut.pht_q[k]);
      end
    end
    checks++;
    if (dut.pht_q[4] !== 2'd1) begin
      failures++;
      $display("FAIL full_dropped_pht4 got=%0d exp=1", dut.pht_q[4]);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 64'h10, 1'b0, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b1);
      checks++;
      if (bp.mispredict !== exp_misp) begin
        failures++;
        $display("FAIL sat_misp[%0d] got=%0b exp=%0b", k, bp.mispredict, exp_misp);
      end
    end
    checks++;
    if (dut.pht_q[4] !== 2'd3) begin
      failures++;
      $display("FAIL sat_top got=%0d exp=3", dut.pht_q[4]);
    end
    step(1'b1, 64'h10, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    checks++;
    if (bp.mispredict !== 1'b1) begin
      failures++;
      $display("FAIL sat_nt_misp got=%0b exp=1", bp.mispredict);
    end
    checks++;
    if (dut.pht_q[4] !== 2'd2) begin
      failures++;
      $display("FAIL sat_dec got=%0d exp=2", dut.pht_q[4]);
    end
    step(1'b1, 64'h10, 1'b0, 1'b0);
    checks++;
    if (obs_pred !== 1'b1) begin
      failures++;
      $display("FAIL sat_pred got=%0b exp=1", obs_pred);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    step(1'b1, 64'h20, 1'b0, 1'b0);
    step(1'b1, 64'h24, 1'b0, 1'b0);
    step(1'b1, 64'h28, 1'b0, 1'b0);
    checks++;
    if (bp.inflight !== 3'd3) begin
      failures++;
      $display("FAIL flush_pre_inflight got=%0d exp=3", bp.inflight);
    end
    step(1'b1, 64'h2C, 1'b1, 1'b1);
    checks++;
    if (bp.mispredict !== 1'b1) begin
      failures++;
      $display("FAIL flush_misp got=%0b exp=1", bp.mispredict);
    end
    checks++;
    if (bp.inflight !== 3'd0) begin
      failures++;
      $display("FAIL flush_inflight got=%0d exp=0", bp.inflight);
    end
    checks++;
    if (dut.pht_q[8] !== 2'd2) begin
      failures++;
      $display("FAIL flush_train got=%0d exp=2", dut.pht_q[8]);
    end
    step(1'b0, 64'h0, 1'b0, 1'b0);
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL flush_pulse_len got=%0b exp=0", bp.mispredict);
    end
  endtask

  task automatic test_empty_resolve();
    step(1'b0, 64'h0, 1'b1, 1'b1);
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL empty_misp got=%0b exp=0", bp.mispredict);
    end
    checks++;
    if (bp.inflight !== 3'd0) begin
      failures++;
      $display("FAIL empty_inflight got=%0d exp=0", bp.inflight);
    end
    for (int i = 0; i < NENT; i++) begin
      checks++;
      if (dut.pht_q[i] !== mdl_pht[i]) begin
        failures++;
        $display("FAIL empty_pht[%0d] got=%0d exp=%0d", i, dut.pht_q[i], mdl_pht[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    step(1'b1, 64'h4, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 64'h4, 1'b1, 1'b0);
      checks++;
      if (bp.mispredict !== 1'b0 || bp.inflight !== 3'd1) begin
        failures++;
        $display("FAIL b2b[%0d] got misp=%0b infl=%0d exp misp=0 infl=1",
                 k, bp.mispredict, bp.inflight);
      end
      checks++;
      if (obs_pred !== exp_pred) begin
        failures++;
        $display("FAIL b2b_pred[%0d] got=%0b exp=%0b", k, obs_pred, exp_pred);
      end
    end
    checks++;
    if (dut.pht_q[1] !== 2'd0) begin
      failures++;
      $display("FAIL b2b_pht1 got=%0d exp=0", dut.pht_q[1]);
    end
  endtask

  task automatic test_same_index();
    apply_reset();
    step(1'b1, 64'h40, 1'b0, 1'b0);
    step(1'b1, 64'h40, 1'b1, 1'b1);
    checks++;
    if (obs_pred !== 1'b0) begin
      failures++;
      $display("FAIL same_idx_preupdate got=%0b exp=0", obs_pred);
    end
    checks++;
    if (bp.mispredict !== 1'b1 || bp.inflight !== 3'd0) begin
      failures++;
      $display("FAIL same_idx_flush got misp=%0b infl=%0d exp misp=1 infl=0",
               bp.mispredict, bp.inflight);
    end
    step(1'b1, 64'h40, 1'b0, 1'b0);
    checks++;
    if (obs_pred !== 1'b1) begin
      failures++;
      $display("FAIL same_idx_post got=%0b exp=1", obs_pred);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(1'b1, 64'h30, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 64'h34, 1'b0, 1'b0);
    step(1'b1, 64'h38, 1'b0, 1'b0);
    checks++;
    if (bp.inflight !== 3'd2 || dut.pht_q[12] !== 2'd2) begin
      failures++;
      $display("FAIL rmid_pre got infl=%0d pht12=%0d exp infl=2 pht12=2",
               bp.inflight, dut.pht_q[12]);
    end
    @(negedge clk);
    bp.fetch_valid   = 1'b0;
    bp.resolve_valid = 1'b1;
    bp.resolve_taken = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bp.inflight !== 3'd0) begin
      failures++;
      $display("FAIL rmid_inflight got=%0d exp=0", bp.inflight);
    end
    checks++;
    if (bp.mispredict !== 1'b0 || bp.fetch_stall !== 1'b0) begin
      failures++;
      $display("FAIL rmid_outs got misp=%0b stall=%0b exp 0 0",
               bp.mispredict, bp.fetch_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL rmid_pulse got=%0b exp=0", bp.mispredict);
    end
    for (int i = 0; i < NENT; i++) begin
      checks++;
      if (dut.pht_q[i] !== 2'd1) begin
        failures++;
        $display("FAIL rmid_pht[%0d] got=%0d exp=1", i, dut.pht_q[i]);
      end
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    step(1'b0, 64'h0, 1'b0, 1'b0);
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL rmid_after got=%0b exp=0", bp.mispredict);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_saturate();
    test_flush();
    test_empty_resolve();
    test_back_to_back();
    test_same_index();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
